// File: rtl/stack_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : stack_pkg
//  Purpose  : Shared codes for the typed operand stack: value types, command
//             op codes, trap codes and controller state encodings.
//  Revision : 1.0  initial release
// ============================================================================
package stack_pkg;

   // Value type tags carried alongside every stack entry
   typedef enum logic [1:0] {
      T_I32 = 2'd0,
      T_I64 = 2'd1,
      T_F32 = 2'd2,
      T_F64 = 2'd3
   } val_type_e;

   // Command op codes (codes 6 and 7 behave as NOP)
   localparam logic [2:0] OP_NOP       = 3'd0;
   localparam logic [2:0] OP_PUSH      = 3'd1;
   localparam logic [2:0] OP_POP       = 3'd2;
   localparam logic [2:0] OP_GET_LOCAL = 3'd3;
   localparam logic [2:0] OP_SET_LOCAL = 3'd4;
   localparam logic [2:0] OP_TEE_LOCAL = 3'd5;

   // Sticky trap codes
   localparam logic [3:0] TRAP_NONE          = 4'd0;
   localparam logic [3:0] TRAP_OVERFLOW      = 4'd1;
   localparam logic [3:0] TRAP_UNDERFLOW     = 4'd2;
   localparam logic [3:0] TRAP_LOCAL_OOB     = 4'd3;
   localparam logic [3:0] TRAP_NO_64B        = 4'd4;
   localparam logic [3:0] TRAP_TYPE_MISMATCH = 4'd5;

   // Controller states
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_TRAP = 2'd2;

   // True for the 64-bit value types
   function automatic logic is_wide(input logic [1:0] t);
      return (t == T_I64) || (t == T_F64);
   endfunction

endpackage
`default_nettype wire

// File: rtl/stack_ram.sv
`default_nettype none
// ============================================================================
//  Module   : stack_ram
//  Purpose  : One-write / one-read synchronous RAM with a registered read
//             port; holds every stack entry below the cached top.
//  Revision : 1.0  initial release
// ============================================================================
module stack_ram
   import stack_pkg::*;
#(
   parameter int AW = 8,
   parameter int W  = 66
)(
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [W-1:0]  wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [W-1:0]  rdata_o
);

   logic [W-1:0] mem_q [0:(2**AW)-1];
   logic [W-1:0] rdata_q;

   // Write port
   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   // Registered read port; a same-edge write is not visible to the read
   always_ff @(posedge clk) begin
      if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/value_stack.sv
`default_nettype none
// ============================================================================
//  Module   : value_stack
//  Purpose  : Typed operand stack with cached top entry, push/pop and
//             frame-relative local get/set/tee, valid/ready command handshake
//             and sticky traps.
//  Options  : STACK_TYPE_CHECK_EN - SET_LOCAL/TEE_LOCAL trap on type mismatch
//  Revision : 1.0  initial release
// ============================================================================
module value_stack
   import stack_pkg::*;
#(
   parameter int STACK_DEPTH = 7,
   parameter int DATA_W      = 64
)(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   op_valid,
   output logic                   op_ready,
   input  logic [2:0]             op,
   input  logic [DATA_W-1:0]      in_data,
   input  logic [1:0]             in_type,
   input  logic [STACK_DEPTH:0]   frame_base,
   input  logic [STACK_DEPTH:0]   local_idx,
   output logic [DATA_W-1:0]      top_data,
   output logic [1:0]             top_type,
   output logic                   empty,
   output logic [STACK_DEPTH+1:0] count,
   output logic [3:0]             trap
);

   localparam int IW = STACK_DEPTH + 1;
   localparam int CW = STACK_DEPTH + 2;
   localparam logic [CW-1:0] FULL = {1'b1, {IW{1'b0}}};
   localparam logic [CW-1:0] ONE  = {{IW{1'b0}}, 1'b1};
   localparam logic [CW-1:0] TWO  = ONE + ONE;

   logic [1:0]        state_q, state_d;
   logic [CW-1:0]     count_q, count_d;
   logic [DATA_W-1:0] top_data_q, top_data_d;
   logic [1:0]        top_type_q, top_type_d;
   logic [3:0]        trap_q, trap_d;
   logic [2:0]        ex_op_q, ex_op_d;
   logic              ex_use_top_q, ex_use_top_d;

   logic              accept;
   logic [CW-1:0]     addr;
   logic [CW-1:0]     cnt_m1, cnt_m2;
   logic [3:0]        trap_code;
   logic              type_bad;

   logic              ram_we, ram_re;
   logic [IW-1:0]     ram_waddr, ram_raddr;
   logic [DATA_W+1:0] ram_wdata, ram_rdata;

   assign accept = op_valid && (state_q == ST_IDLE);
   assign addr   = {1'b0, frame_base} + {1'b0, local_idx};
   assign cnt_m1 = count_q - ONE;
   assign cnt_m2 = count_q - TWO;

`ifdef STACK_TYPE_CHECK_EN
   // Shadow copy of the type tag of every RAM entry, readable in the
   // acceptance cycle so a single-cycle TEE_LOCAL can be checked
   logic [1:0] ltype_q [0:(2**IW)-1];

   // Shadow type tags follow every RAM write
   always_ff @(posedge clk) begin
      if (ram_we) ltype_q[ram_waddr] <= ram_wdata[1:0];
   end

   assign type_bad = (ltype_q[addr[IW-1:0]] != top_type_q);
`else
   assign type_bad = 1'b0;
`endif

   // Classify the offered command into a trap code (TRAP_NONE when legal)
   always_comb begin
      trap_code = TRAP_NONE;
      case (op)
         OP_PUSH: begin
            if (count_q == FULL)                       trap_code = TRAP_OVERFLOW;
            else if ((DATA_W == 32) && is_wide(in_type)) trap_code = TRAP_NO_64B;
         end
         OP_POP: begin
            if (count_q == '0) trap_code = TRAP_UNDERFLOW;
         end
         OP_GET_LOCAL: begin
            if (count_q == FULL)      trap_code = TRAP_OVERFLOW;
            else if (addr >= count_q) trap_code = TRAP_LOCAL_OOB;
         end
         OP_SET_LOCAL, OP_TEE_LOCAL: begin
            if (count_q == '0)       trap_code = TRAP_UNDERFLOW;
            else if (addr >= cnt_m1) trap_code = TRAP_LOCAL_OOB;
            else if (type_bad)       trap_code = TRAP_TYPE_MISMATCH;
         end
         default: trap_code = TRAP_NONE;
      endcase
   end

   // RAM port control: writes and reads are issued on the acceptance edge
   always_comb begin
      ram_we    = 1'b0;
      ram_re    = 1'b0;
      ram_waddr = addr[IW-1:0];
      ram_raddr = cnt_m2[IW-1:0];
      ram_wdata = {top_data_q, top_type_q};
      if (accept && (trap_code == TRAP_NONE)) begin
         case (op)
            OP_PUSH: begin
               ram_we    = (count_q != '0);
               ram_waddr = cnt_m1[IW-1:0];
            end
            OP_POP: ram_re = 1'b1;
            OP_GET_LOCAL: begin
               // old top sinks into RAM while the local is fetched
               ram_we    = 1'b1;
               ram_waddr = cnt_m1[IW-1:0];
               ram_re    = 1'b1;
               ram_raddr = addr[IW-1:0];
            end
            OP_SET_LOCAL: begin
               ram_we = 1'b1;
               ram_re = 1'b1;
            end
            OP_TEE_LOCAL: ram_we = 1'b1;
            default: ram_we = 1'b0;
         endcase
      end
   end

   // Controller next state: accept/trap in IDLE, finish two-cycle ops in EXEC
   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      top_data_d   = top_data_q;
      top_type_d   = top_type_q;
      trap_d       = trap_q;
      ex_op_d      = ex_op_q;
      ex_use_top_d = ex_use_top_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (trap_code != TRAP_NONE) begin
                  trap_d  = trap_code;
                  state_d = ST_TRAP;
               end else begin
                  case (op)
                     OP_PUSH: begin
                        top_data_d = in_data;
                        top_type_d = in_type;
                        count_d    = count_q + ONE;
                     end
                     OP_POP, OP_GET_LOCAL, OP_SET_LOCAL: begin
                        state_d = ST_EXEC;
                        ex_op_d = op;
                        // the wanted value is the current top register
                        ex_use_top_d = ((op == OP_GET_LOCAL) && (addr == cnt_m1)) ||
                                       ((op == OP_SET_LOCAL) && (addr == cnt_m2));
                     end
                     default: state_d = ST_IDLE;
                  endcase
               end
            end
         end
         ST_EXEC: begin
            state_d = ST_IDLE;
            case (ex_op_q)
               OP_POP: begin
                  count_d = cnt_m1;
                  if (cnt_m1 == '0) begin
                     top_data_d = '0;
                     top_type_d = '0;
                  end else begin
                     top_data_d = ram_rdata[DATA_W+1:2];
                     top_type_d = ram_rdata[1:0];
                  end
               end
               OP_GET_LOCAL: begin
                  count_d = count_q + ONE;
                  if (!ex_use_top_q) begin
                     top_data_d = ram_rdata[DATA_W+1:2];
                     top_type_d = ram_rdata[1:0];
                  end
               end
               OP_SET_LOCAL: begin
                  count_d = cnt_m1;
                  if (!ex_use_top_q) begin
                     top_data_d = ram_rdata[DATA_W+1:2];
                     top_type_d = ram_rdata[1:0];
                  end
               end
               default: count_d = count_q;
            endcase
         end
         ST_TRAP: state_d = ST_TRAP;
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers with asynchronous reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         count_q      <= '0;
         top_data_q   <= '0;
         top_type_q   <= '0;
         trap_q       <= TRAP_NONE;
         ex_op_q      <= OP_NOP;
         ex_use_top_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         top_data_q   <= top_data_d;
         top_type_q   <= top_type_d;
         trap_q       <= trap_d;
         ex_op_q      <= ex_op_d;
         ex_use_top_q <= ex_use_top_d;
      end
   end

   stack_ram #(
      .AW (IW),
      .W  (DATA_W + 2)
   ) u_ram (
      .clk     (clk),
      .we_i    (ram_we),
      .waddr_i (ram_waddr),
      .wdata_i (ram_wdata),
      .re_i    (ram_re),
      .raddr_i (ram_raddr),
      .rdata_o (ram_rdata)
   );

   assign op_ready = (state_q == ST_IDLE);
   assign top_data = top_data_q;
   assign top_type = top_type_q;
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign trap     = trap_q;

endmodule
`default_nettype wire

// File: tb/tb_value_stack.sv
`default_nettype none
// ============================================================================
//  Module   : tb_value_stack
//  Purpose  : Directed self-checking bench for value_stack (64-bit default
//             instance plus a small 32-bit instance).
//  Revision : 1.0  initial release
// ============================================================================
module tb_value_stack;
   import stack_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        v64 = 1'b0, v32 = 1'b0;
   logic        rdy64, rdy32;
   logic [2:0]  op = 3'd0;
   logic [63:0] din = 64'd0;
   logic [1:0]  dtype = 2'd0;
   logic [7:0]  fb = 8'd0, li = 8'd0;

   logic [63:0] top64;
   logic [1:0]  tt64;
   logic        e64;
   logic [8:0]  c64;
   logic [3:0]  tr64;
   logic [31:0] top32;
   logic [1:0]  tt32;
   logic        e32;
   logic [3:0]  c32;
   logic [3:0]  tr32;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   value_stack u_dut (
      .clk (clk), .reset (reset), .op_valid (v64), .op_ready (rdy64),
      .op (op), .in_data (din), .in_type (dtype), .frame_base (fb),
      .local_idx (li), .top_data (top64), .top_type (tt64), .empty (e64),
      .count (c64), .trap (tr64)
   );

   value_stack #(.STACK_DEPTH (2), .DATA_W (32)) u_dut32 (
      .clk (clk), .reset (reset), .op_valid (v32), .op_ready (rdy32),
      .op (op), .in_data (din[31:0]), .in_type (dtype), .frame_base (fb[2:0]),
      .local_idx (li[2:0]), .top_data (top32), .top_type (tt32), .empty (e32),
      .count (c32), .trap (tr32)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Offer one command to the chosen DUT and wait until it completes or traps
   task automatic issue(input bit s32, input logic [2:0] o, input logic [63:0] d,
                        input logic [1:0] t, input logic [7:0] b, input logic [7:0] k);
      int n;
      @(negedge clk);
      op = o; din = d; dtype = t; fb = b; li = k;
      if (s32) v32 = 1'b1; else v64 = 1'b1;
      @(posedge clk);
      #1;
      v32 = 1'b0; v64 = 1'b0;
      n = 0;
      @(negedge clk);
      while (!(s32 ? (rdy32 || (tr32 != 4'd0)) : (rdy64 || (tr64 != 4'd0))) && (n < 10)) begin
         @(negedge clk);
         n++;
      end
      chk("cmd_done", 64'(n < 10), 64'd1);
   endtask

   initial begin
      do_reset;
      // reset state
      chk("rst_top", top64, 64'd0);
      chk("rst_type", 64'(tt64), 64'd0);
      chk("rst_empty", 64'(e64), 64'd1);
      chk("rst_count", 64'(c64), 64'd0);
      chk("rst_trap", 64'(tr64), 64'd0);
      chk("rst_ready", 64'(rdy64), 64'd1);

      // SET_LOCAL with forwarding of the written value
      issue(0, OP_PUSH, 64'd1, T_I64, 8'd0, 8'd0);
      issue(0, OP_PUSH, 64'd3, T_I64, 8'd0, 8'd0);
      issue(0, OP_SET_LOCAL, 64'd0, T_I32, 8'd0, 8'd0);
      chk("set_count", 64'(c64), 64'd1);
      chk("set_top", top64, 64'd3);
      chk("set_type", 64'(tt64), 64'(T_I64));
      chk("set_empty", 64'(e64), 64'd0);
      chk("set_trap", 64'(tr64), 64'd0);

      // GET_LOCAL, POP, TEE_LOCAL and non-forwarded SET_LOCAL
      do_reset;
      issue(0, OP_PUSH, 64'd5, T_I32, 8'd0, 8'd0);
      issue(0, OP_PUSH, 64'd7, T_I32, 8'd0, 8'd0);
      issue(0, OP_GET_LOCAL, 64'd0, T_I32, 8'd0, 8'd0);
      chk("get_count", 64'(c64), 64'd3);
      chk("get_top", top64, 64'd5);
      issue(0, OP_POP, 64'd0, T_I32, 8'd0, 8'd0);
      chk("pop1_top", top64, 64'd7);
      issue(0, OP_POP, 64'd0, T_I32, 8'd0, 8'd0);
      chk("pop2_top", top64, 64'd5);
      chk("pop2_count", 64'(c64), 64'd1);
      issue(0, OP_GET_LOCAL, 64'd0, T_I32, 8'd0, 8'd0);
      chk("gettop_top", top64, 64'd5);
      chk("gettop_count", 64'(c64), 64'd2);
      issue(0, OP_PUSH, 64'd9, T_I32, 8'd0, 8'd0);
      issue(0, OP_TEE_LOCAL, 64'd0, T_I32, 8'd0, 8'd0);
      chk("tee_count", 64'(c64), 64'd3);
      chk("tee_top", top64, 64'd9);
      issue(0, OP_PUSH, 64'd4, T_I32, 8'd0, 8'd0);
      issue(0, OP_SET_LOCAL, 64'd0, T_I32, 8'd0, 8'd0);
      chk("set2_top", top64, 64'd9);
      chk("set2_count", 64'(c64), 64'd3);
      issue(0, OP_GET_LOCAL, 64'd0, T_I32, 8'd0, 8'd0);
      chk("get2_top", top64, 64'd4);
      issue(0, OP_GET_LOCAL, 64'd0, T_I32, 8'd1, 8'd0);
      chk("getfb_top", top64, 64'd5);
      chk("getfb_count", 64'(c64), 64'd5);
      issue(0, 3'd7, 64'd0, T_I32, 8'd0, 8'd0);
      chk("nop_count", 64'(c64), 64'd5);
      chk("nop_top", top64, 64'd5);

      // POP down to empty clears the top
      do_reset;
      issue(0, OP_PUSH, 64'h77, T_F32, 8'd0, 8'd0);
      issue(0, OP_POP, 64'd0, T_I32, 8'd0, 8'd0);
      chk("popz_top", top64, 64'd0);
      chk("popz_type", 64'(tt64), 64'd0);
      chk("popz_empty", 64'(e64), 64'd1);

      // Underflow trap is sticky and blocks further commands
      do_reset;
      issue(0, OP_POP, 64'd0, T_I32, 8'd0, 8'd0);
      chk("uf_trap", 64'(tr64), 64'd2);
      chk("uf_ready", 64'(rdy64), 64'd0);
      @(negedge clk);
      op = OP_PUSH; din = 64'h55; dtype = T_I32; v64 = 1'b1;
      repeat (3) @(negedge clk);
      v64 = 1'b0;
      chk("uf_hold_trap", 64'(tr64), 64'd2);
      chk("uf_hold_ready", 64'(rdy64), 64'd0);
      chk("uf_hold_count", 64'(c64), 64'd0);
      do_reset;
      chk("uf_clr_trap", 64'(tr64), 64'd0);
      chk("uf_clr_ready", 64'(rdy64), 64'd1);

      // Fill to capacity, then overflow
      for (int i = 0; i < 256; i++) issue(0, OP_PUSH, 64'h100 + 64'(i), 2'(i), 8'd0, 8'd0);
      chk("full_count", 64'(c64), 64'd256);
      chk("full_top", top64, 64'h1FF);
      chk("full_type", 64'(tt64), 64'd3);
      issue(0, OP_PUSH, 64'hABC, T_I32, 8'd0, 8'd0);
      chk("of_trap", 64'(tr64), 64'd1);
      chk("of_count", 64'(c64), 64'd256);
      chk("of_top", top64, 64'h1FF);

      // Local out of range
      do_reset;
      issue(0, OP_PUSH, 64'd1, T_I32, 8'd0, 8'd0);
      issue(0, OP_PUSH, 64'd2, T_I32, 8'd0, 8'd0);
      issue(0, OP_GET_LOCAL, 64'd0, T_I32, 8'd0, 8'd2);
      chk("oob_get_trap", 64'(tr64), 64'd3);
      chk("oob_get_count", 64'(c64), 64'd2);
      do_reset;
      issue(0, OP_PUSH, 64'd1, T_I32, 8'd0, 8'd0);
      issue(0, OP_SET_LOCAL, 64'd0, T_I32, 8'd0, 8'd0);
      chk("oob_set_trap", 64'(tr64), 64'd3);
      chk("oob_set_count", 64'(c64), 64'd1);

      // 64-bit types rejected by the 32-bit instance
      do_reset;
      issue(1, OP_PUSH, 64'h12345678, T_I32, 8'd0, 8'd0);
      chk("w32_top", 64'(top32), 64'h12345678);
      chk("w32_count", 64'(c32), 64'd1);
      issue(1, OP_PUSH, 64'h9, T_F64, 8'd0, 8'd0);
      chk("w32_trap", 64'(tr32), 64'd4);
      chk("w32_trap_count", 64'(c32), 64'd1);
      chk("w32_trap_top", 64'(top32), 64'h12345678);

      // TEE_LOCAL onto a local of a different type
      do_reset;
      issue(0, OP_PUSH, 64'd1, T_I32, 8'd0, 8'd0);
      issue(0, OP_PUSH, 64'd2, T_F32, 8'd0, 8'd0);
      issue(0, OP_TEE_LOCAL, 64'd0, T_I32, 8'd0, 8'd0);
`ifdef STACK_TYPE_CHECK_EN
      chk("tc_trap", 64'(tr64), 64'd5);
      chk("tc_count", 64'(c64), 64'd2);
      chk("tc_top", top64, 64'd2);
`else
      chk("tc_trap", 64'(tr64), 64'd0);
      issue(0, OP_GET_LOCAL, 64'd0, T_I32, 8'd0, 8'd0);
      chk("tc_local_data", top64, 64'd2);
      chk("tc_local_type", 64'(tt64), 64'(T_F32));
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
